// File: rtl/thunderbolt_cmd_scheduler.sv
// thunderbolt_cmd_scheduler: arbitrates host and periodic poll commands, frames them as DLE-stuffed TSIP packets for the TX UART
// Ports: i_clk, i_rst (async active-low); host request i_host_req/i_host_id/i_host_len/i_host_payload with o_host_ack;
//   UART byte stream o_tx_data/o_tx_valid/i_tx_ready; i_thunder_packet_dv from the receiver;
//   status o_busy, o_timeout (pulse), o_timeout_cnt (saturating).
// Define THUNDER_POLL_EN to build the poll requester and response watchdog; otherwise only host commands are sent.
module thunderbolt_cmd_scheduler #(
  parameter int POLL_CYCLES = 50_000_000,
  parameter int TIMEOUT_CYCLES = 25_000_000,
  parameter logic [7:0] POLL_ID = 8'h21
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_host_req,
  input  logic [7:0]  i_host_id,
  input  logic [2:0]  i_host_len,
  input  logic [31:0] i_host_payload,
  output logic        o_host_ack,
  output logic [7:0]  o_tx_data,
  output logic        o_tx_valid,
  input  logic        i_tx_ready,
  input  logic        i_thunder_packet_dv,
  output logic        o_busy,
  output logic        o_timeout,
  output logic [7:0]  o_timeout_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_START, S_ID, S_PAYLOAD, S_STUFF, S_END, S_ETX} state_t;
  state_t state, state_nx;
  logic [7:0] id_r;
  logic [31:0] pay_r;
  logic [2:0] rem;
  logic hs, host_take, poll_take;
  assign hs = o_tx_valid & i_tx_ready;
  assign host_take = i_rst & (state == S_IDLE) & i_host_req;
`ifdef THUNDER_POLL_EN
  localparam int PW = $clog2(POLL_CYCLES);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  logic [PW-1:0] poll_cnt;
  logic [TW-1:0] wd_cnt;
  logic poll_pending, is_poll, wd_armed, tick;
  assign tick = poll_cnt == PW'(POLL_CYCLES - 1);
  assign poll_take = (state == S_IDLE) & ~i_host_req & poll_pending;
  assign o_timeout = wd_armed & ~i_thunder_packet_dv & (wd_cnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      poll_cnt <= '0;
      poll_pending <= 1'b0;
      is_poll <= 1'b0;
      wd_armed <= 1'b0;
      wd_cnt <= '0;
      o_timeout_cnt <= 8'h00;
    end else begin
      poll_cnt <= tick ? '0 : poll_cnt + 1'b1;
      // a tick landing while a request is already pending is dropped
      poll_pending <= poll_take ? 1'b0 : poll_pending | tick;
      if (state == S_IDLE) is_poll <= poll_take;
      if (state == S_ETX && hs && is_poll) begin
        wd_armed <= 1'b1;
        wd_cnt <= '0;
      end else if (wd_armed) begin
        wd_armed <= ~(i_thunder_packet_dv | (wd_cnt == TW'(TIMEOUT_CYCLES - 1)));
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (o_timeout && o_timeout_cnt != 8'hff) o_timeout_cnt <= o_timeout_cnt + 1'b1;
    end
`else
  logic unused_cfg;
  assign unused_cfg = i_thunder_packet_dv ^ (POLL_CYCLES > TIMEOUT_CYCLES);
  assign poll_take = 1'b0;
  assign o_timeout = 1'b0;
  assign o_timeout_cnt = 8'h00;
`endif
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) state <= S_IDLE;
    else state <= state_nx;
  // rem counts payload bytes still to send; it drops on each payload handshake,
  // so after a stuffed byte the same test picks PAYLOAD or END for both ID and payload
  always_ff @(posedge i_clk or negedge i_rst)
    if (!i_rst) begin
      id_r <= 8'h00;
      pay_r <= 32'h0;
      rem <= 3'd0;
    end else if (host_take) begin
      id_r <= i_host_id;
      pay_r <= i_host_payload;
      rem <= i_host_len > 3'd4 ? 3'd4 : i_host_len;
    end else if (poll_take) begin
      id_r <= POLL_ID;
      rem <= 3'd0;
    end else if (state == S_PAYLOAD && hs) begin
      pay_r <= pay_r << 8;
      rem <= rem - 1'b1;
    end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    state_nx = (host_take | poll_take) ? S_START : S_IDLE;
      S_START:   if (hs) state_nx = S_ID;
      S_ID:      if (hs) state_nx = id_r == 8'h10 ? S_STUFF : rem != 3'd0 ? S_PAYLOAD : S_END;
      S_PAYLOAD: if (hs) state_nx = pay_r[31:24] == 8'h10 ? S_STUFF : rem == 3'd1 ? S_END : S_PAYLOAD;
      S_STUFF:   if (hs) state_nx = rem != 3'd0 ? S_PAYLOAD : S_END;
      S_END:     if (hs) state_nx = S_ETX;
      S_ETX:     if (hs) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    o_busy = state != S_IDLE;
    o_tx_valid = state != S_IDLE;
    o_host_ack = host_take;
    o_tx_data = state == S_ID ? id_r :
                state == S_PAYLOAD ? pay_r[31:24] :
                state == S_ETX ? 8'h03 :
                state == S_IDLE ? 8'h00 : 8'h10;
  end
endmodule

// File: tb/tb_thunderbolt_cmd_scheduler.sv
// tb_thunderbolt_cmd_scheduler: directed and randomized self-checking bench using a packet-queue reference model
module tb_thunderbolt_cmd_scheduler;
  localparam int PC = 20;
  localparam int TO = 10;
`ifdef THUNDER_POLL_EN
  localparam bit POLL_EN = 1'b1;
`else
  localparam bit POLL_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic host_req = 1'b0;
  logic [7:0] host_id = 8'h00;
  logic [2:0] host_len = 3'd0;
  logic [31:0] host_payload = 32'h0;
  logic tx_ready = 1'b1;
  logic dv = 1'b0;
  logic host_ack, tx_valid, busy, timeout;
  logic [7:0] tx_data, tcnt_o;
  thunderbolt_cmd_scheduler #(.POLL_CYCLES(PC), .TIMEOUT_CYCLES(TO), .POLL_ID(8'h21)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_host_req(host_req), .i_host_id(host_id),
    .i_host_len(host_len), .i_host_payload(host_payload), .o_host_ack(host_ack),
    .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
    .i_thunder_packet_dv(dv), .o_busy(busy), .o_timeout(timeout), .o_timeout_cnt(tcnt_o)
  );
  always #5 clk = ~clk;
  int tests = 0, fails = 0;
  int cyc = 0, rmode = 0;
  logic [7:0] q[$];
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];
  bit cur_poll = 0, pend = 0, wd_on = 0, prev_stall = 0;
  int pcnt = 0, wd_age = 0, mtcnt = 0, etx_n = 0, etx_cyc = 0, to_n = 0, to_cyc = 0;
  logic [7:0] prev_data = 8'h00;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    assert (got === want) else begin
      fails++;
      $error("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask
  function automatic void load(input logic [7:0] id, input logic [2:0] len, input logic [31:0] p);
    int n = len > 3'd4 ? 4 : int'(len);
    q = {8'h10, id};
    if (id == 8'h10) q.push_back(8'h10);
    for (int i = 0; i < n; i++) begin
      logic [7:0] b;
      b = p[31 - 8 * i -: 8];
      q.push_back(b);
      if (b == 8'h10) q.push_back(b);
    end
    q.push_back(8'h10);
    q.push_back(8'h03);
  endfunction
  always @(negedge clk) begin : mon
    logic mbusy, mto, arm, take;
    cyc++;
    if (!rst_n) begin
      chk("rst_valid", 32'(tx_valid), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_ack", 32'(host_ack), 0);
      chk("rst_timeout", 32'(timeout), 0);
      chk("rst_tcnt", 32'(tcnt_o), 0);
      chk("rst_data", 32'(tx_data), 0);
      q.delete();
      cur_poll = 0; pend = 0; pcnt = 0; wd_on = 0; wd_age = 0; mtcnt = 0; prev_stall = 0;
    end else begin
      mbusy = q.size() != 0;
      mto = wd_on && wd_age == TO - 1 && !dv;
      chk("busy", 32'(busy), 32'(mbusy));
      chk("valid", 32'(tx_valid), 32'(mbusy));
      chk("ack", 32'(host_ack), 32'(!mbusy && host_req));
      chk("timeout", 32'(timeout), 32'(mto));
      chk("tcnt", 32'(tcnt_o), 32'(mtcnt));
      if (mbusy) chk("data", 32'(tx_data), 32'(q[0]));
      if (prev_stall) chk("stable", 32'(tx_data), 32'(prev_data));
      prev_stall = tx_valid && !tx_ready;
      prev_data = tx_data;
      if (tx_valid && tx_ready) log_q.push_back(tx_data);
      if (timeout) begin to_n++; to_cyc = cyc; end
      if (mto) mtcnt = mtcnt == 255 ? 255 : mtcnt + 1;
      arm = mbusy && tx_ready && q.size() == 1 && cur_poll;
      if (arm) begin
        wd_on = 1; wd_age = 0; etx_n++; etx_cyc = cyc;
      end else if (wd_on) begin
        if (dv || wd_age == TO - 1) wd_on = 0;
        wd_age++;
      end
      if (mbusy && tx_ready) void'(q.pop_front());
      take = 0;
      if (!mbusy && host_req) begin
        load(host_id, host_len, host_payload);
        cur_poll = 0;
      end else if (!mbusy && pend) begin
        load(8'h21, 3'd0, 32'h0);
        cur_poll = 1;
        take = 1;
      end
      pend = take ? 1'b0 : (pend || (POLL_EN && pcnt == PC - 1));
      pcnt = pcnt == PC - 1 ? 0 : pcnt + 1;
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
    tx_ready = rmode == 0 ? 1'b1 : rmode == 1 ? !tx_ready : rmode == 2 ? 1'($urandom_range(0, 1)) : (cyc % 8 == 0);
  endtask
  task automatic host(input logic [7:0] id, input logic [2:0] len, input logic [31:0] p, output int st);
    int n = 0;
    host_id = id; host_len = len; host_payload = p; host_req = 1'b1;
    #1;
    while (!host_ack && n < 600) begin tick(); n++; end
    chk("host_ack_wait", 32'(host_ack), 1);
    st = log_q.size();
    tick();
    host_req = 1'b0;
  endtask
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 600) begin tick(); n++; end
    chk("idle_wait", 32'(busy), 0);
  endtask
  task automatic chk_pkt(input string tag, input int st);
    chk({tag, "_len"}, 32'(log_q.size() - st), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      if (st + i < log_q.size()) chk(tag, 32'(log_q[st + i]), 32'(exp_q[i]));
  endtask
  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench did not finish");
  end
  initial begin
    int st, n, e0, t0, c0;
    repeat (3) tick();
    rst_n = 1'b1;
    rmode = 0;
    host(8'h8E, 3'd2, 32'hA55A_0000, st);
    wait_idle(n);
    chk("plain_valid_cycles", 32'(n), 6);
    exp_q = {8'h10, 8'h8E, 8'hA5, 8'h5A, 8'h10, 8'h03};
    chk_pkt("plain", st);
    host(8'h10, 3'd1, 32'h1000_0000, st);
    wait_idle(n);
    exp_q = {8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h03};
    chk_pkt("stuff", st);
    rmode = 1;
    host(8'h8E, 3'd2, 32'hA55A_0000, st);
    wait_idle(n);
    exp_q = {8'h10, 8'h8E, 8'hA5, 8'h5A, 8'h10, 8'h03};
    chk_pkt("backpressure", st);
    rmode = 2;
    host(8'h8E, 3'd7, 32'h1122_3344, st);
    wait_idle(n);
    exp_q = {8'h10, 8'h8E, 8'h11, 8'h22, 8'h33, 8'h44, 8'h10, 8'h03};
    chk_pkt("len_clamp", st);
    rmode = 0;
    host(8'h55, 3'd0, 32'hDEAD_BEEF, st);
    wait_idle(n);
    exp_q = {8'h10, 8'h55, 8'h10, 8'h03};
    chk_pkt("len0", st);
`ifdef THUNDER_POLL_EN
    n = 0;
    while (!(q.size() == 0 && pcnt == PC - 1 && !pend) && n < 200) begin tick(); n++; end
    chk("arb_align", 32'(pcnt), PC - 1);
    host(8'h8E, 3'd2, 32'hA55A_0000, st);
    wait_idle(n);
    tick();
    wait_idle(n);
    exp_q = {8'h10, 8'h8E, 8'hA5, 8'h5A, 8'h10, 8'h03, 8'h10, 8'h21, 8'h10, 8'h03};
    chk_pkt("arb", st);
    rmode = 3;
    host(8'h8E, 3'd4, 32'h0102_0304, st);
    wait_idle(n);
    rmode = 0;
    tick();
    wait_idle(n);
    exp_q = {8'h10, 8'h8E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h03, 8'h10, 8'h21, 8'h10, 8'h03};
    chk_pkt("single_poll", st);
    e0 = etx_n; n = 0;
    while (etx_n == e0 && n < 200) begin tick(); n++; end
    chk("wd_etx_wait", 32'(etx_n), 32'(e0 + 1));
    t0 = to_n; c0 = mtcnt; n = 0;
    while (to_n == t0 && n < 40) begin tick(); n++; end
    chk("wd_to_wait", 32'(to_n), 32'(t0 + 1));
    chk("wd_latency", 32'(to_cyc - etx_cyc), TO);
    chk("wd_cnt_inc", 32'(tcnt_o), 32'(c0 + 1));
    e0 = etx_n; n = 0;
    while (etx_n == e0 && n < 200) begin tick(); n++; end
    repeat (4) tick();
    dv = 1'b1;
    tick();
    dv = 1'b0;
    t0 = to_n; c0 = mtcnt;
    repeat (12) tick();
    chk("dv_no_timeout", 32'(to_n), 32'(t0));
    chk("dv_cnt_same", 32'(tcnt_o), 32'(c0));
    e0 = etx_n; n = 0;
    while (etx_n == e0 && n < 200) begin tick(); n++; end
    t0 = to_n;
    repeat (9) tick();
    dv = 1'b1;
    tick();
    dv = 1'b0;
    repeat (5) tick();
    chk("dv_expiry_wins", 32'(to_n), 32'(t0));
`endif
    for (int k = 0; k < 40; k++) begin
      logic [31:0] p;
      logic [7:0] id;
      rmode = $urandom_range(0, 3);
      repeat ($urandom_range(0, 25)) begin
        tick();
        dv = ($urandom_range(0, 15) == 0);
      end
      dv = 1'b0;
      id = ($urandom_range(0, 3) == 0) ? 8'h10 : 8'($urandom);
      p = $urandom;
      if ($urandom_range(0, 1) == 1) p[31:24] = 8'h10;
      if ($urandom_range(0, 1) == 1) p[15:8] = 8'h10;
      host(id, 3'($urandom_range(0, 7)), p, st);
    end
    rmode = 0;
    wait_idle(n);
    rmode = 3;
    host(8'h8E, 3'd4, 32'h0102_0304, st);
    n = 0;
    while (q.size() != 5 && n < 600) begin tick(); n++; end
    chk("reach_payload", 32'(q.size()), 5);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(tx_valid), 0);
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_tcnt", 32'(tcnt_o), 0);
    tick();
    tick();
    rst_n = 1'b1;
    rmode = 0;
    host(8'h8E, 3'd2, 32'hA55A_0000, st);
    wait_idle(n);
    exp_q = {8'h10, 8'h8E, 8'hA5, 8'h5A, 8'h10, 8'h03};
    chk_pkt("after_reset", st);
    repeat (5) tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/thunderbolt_cmd_scheduler.md
# thunderbolt_cmd_scheduler

Sequences all traffic on the serial path to the Thunderbolt GPS receiver. It arbitrates between a host command requester and an internal periodic time-poll requester. It frames the winning command as a TSIP packet, including DLE byte-stuffing, and streams it byte by byte into the TX UART. After each poll it runs a response watchdog against the receive-side packet-valid flag.

## Interface
Parameters:
- POLL_CYCLES, 50_000_000: clock cycles between periodic poll requests (1 s at 50 MHz); must be ≥ 2.
- TIMEOUT_CYCLES, 25_000_000: cycles allowed between poll ETX acceptance and `i_thunder_packet_dv`; must be ≥ 2.
- POLL_ID, 8'h21: TSIP packet ID of the poll command; it has no payload.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  reset; one clock; reset is asynchronous and active-low.
- i_host_req  in  1  host command request; held high until `o_host_ack`.
- i_host_id  in  8  TSIP packet ID of the host command.
- i_host_len  in  3  payload length, 0–4; values 5–7 are treated as 4.
- i_host_payload  in  32  payload bytes; bits [31:24] are sent first.
- o_host_ack  out  1  one-cycle pulse when the host command is latched.
- o_tx_data  out  8  byte to the UART.
- o_tx_valid  out  1  `o_tx_data` is valid.
- i_tx_ready  in  1  UART accepts the byte when `o_tx_valid & i_tx_ready`.
- i_thunder_packet_dv  in  1  receive side has decoded a valid packet.
- o_busy  out  1  a packet is being framed or sent (state ≠ IDLE).
- o_timeout  out  1  one-cycle pulse when the watchdog expires.
- o_timeout_cnt  out  8  count of watchdog expiries; saturates at 255.

## Operation
- **Packet format:** `10`, ID, payload[0..len-1], `10`, `03`.
  - Any ID or payload byte equal to `10` is sent twice (stuffed).
  - The framing bytes are never stuffed.
- **States:** IDLE → START (`10`) → ID → PAYLOAD → END (`10`) → ETX (`03`) → IDLE.
  - STUFF is entered from ID or PAYLOAD after a `10` byte is accepted. It sends `10` again, then resumes at the next field.
  - PAYLOAD is skipped when len = 0.
- **Transitions:** each state advances only on a handshake (`o_tx_valid & i_tx_ready`). `o_tx_data` stays stable while `o_tx_valid` is high and ready is low.
- **Arbitration in IDLE:** fixed priority, host over poll.
  - Host wins when `i_host_req` = 1. ID, length and payload are latched and `o_host_ack` pulses in the same cycle.
  - Otherwise, if `poll_pending` = 1, it is cleared and POLL_ID is latched with len 0.
  - A host request arriving mid-packet waits for IDLE.
  - If req is still high in the cycle after ack, it is a new command.
- **Poll counter:** free-running from 0 to POLL_CYCLES-1.
  - At terminal count it sets `poll_pending` and wraps to 0.
  - A tick while `poll_pending` is already 1 is dropped; requests are not queued.
- **Watchdog:**
  - Arms, with its counter at 0, in the cycle the ETX of a poll packet is accepted. Host packets never arm it.
  - Disarms on `i_thunder_packet_dv`.
  - On reaching TIMEOUT_CYCLES-1 while armed, it disarms, pulses `o_timeout` and increments `o_timeout_cnt`.
  - If `i_thunder_packet_dv` arrives in the expiry cycle, it wins: no timeout.
  - `i_thunder_packet_dv` while disarmed is ignored.
  - Re-arming while already armed restarts the count.

## Timing
- **Reset values:** all outputs are 0; state IDLE; `poll_pending` 0; poll counter 0; watchdog disarmed.
- **Reset mid-packet:** the packet is abandoned. No ETX is sent and no ack is repeated.
- **Packet latency:**
  - `o_tx_valid` rises the cycle after the IDLE latch.
  - With `i_tx_ready` held high, consecutive bytes are 1 cycle apart, giving 4 + len + stuffed-count cycles of valid.
  - `o_busy` falls the cycle after the ETX handshake.
  - A request pending at that point is latched in the first IDLE cycle.
- **Timeout latency:** `o_timeout` pulses TIMEOUT_CYCLES cycles after the ETX handshake cycle.

## Configuration
- **THUNDER_POLL_EN defined:** the poll counter, poll requester and watchdog are built as described.
- **Not defined:**
  - No poll packets are ever sent.
  - `o_timeout` and `o_timeout_cnt` are tied to 0.
  - `i_thunder_packet_dv` is unused.
  - Host commands behave identically.

## Test plan
- **Host, no stuffing:** ID `8E`, len 2, payload `A5 5A` with ready high → bytes `10 8E A5 5A 10 03` on 6 consecutive cycles; `o_host_ack` one pulse.
- **Stuffing:** ID `10`, len 1, payload `10` → `10 10 10 10 10 10 03`, i.e. start, ID stuffed, payload stuffed, end, ETX.
- **Backpressure:** ready toggled 0/1 every cycle → identical byte sequence; data stable while ready low.
- **Arbitration:** POLL_CYCLES = 20; host req and poll tick in the same IDLE cycle → host packet first, then `10 21 10 03`. Extra ticks during the host packet do not yield a second poll.
- **Watchdog:** TIMEOUT_CYCLES = 10, no dv after poll ETX → `o_timeout` pulse 10 cycles later and cnt = 1. Repeat with dv 5 cycles after ETX → no pulse, cnt unchanged.
- **Reset mid-packet:** assert `i_rst` low during PAYLOAD → `o_tx_valid`, `o_busy` and `o_timeout_cnt` go to 0 immediately. After release, the next host request sends a full packet.
